// File: rtl/square_iter_if.sv
// Operand/result bundle for the iterative squaring unit.
// Master drives the unpacked operand, slave returns the unpacked result.
interface square_iter_if;
  logic              n_valid;
  logic              is_nan_in;
  logic              is_pinf_in;
  logic              is_ninf_in;
  logic              is_num;
  logic              sign_in;
  logic [10:0]       mant_in;
  logic signed [6:0] exp_in;
  logic              busy;
  logic              it_valid;
  logic              result;
  logic              sign_out;
  logic signed [6:0] exp_out;
  logic [10:0]       mant_out;
  logic              is_nan_out;
  logic              is_pinf_out;
  logic              is_ninf_out;

  modport master (
    output n_valid, is_nan_in, is_pinf_in,
    output is_ninf_in, is_num, sign_in,
    output mant_in, exp_in,
    input  busy, it_valid, result, sign_out,
    input  exp_out, mant_out,
    input  is_nan_out, is_pinf_out, is_ninf_out
  );

  modport slave (
    input  n_valid, is_nan_in, is_pinf_in,
    input  is_ninf_in, is_num, sign_in,
    input  mant_in, exp_in,
    output busy, it_valid, result, sign_out,
    output exp_out, mant_out,
    output is_nan_out, is_pinf_out, is_ninf_out
  );
endinterface

// File: rtl/square_iter.sv
// Iterative half-precision squarer: 11-step LSB-first shift-add
// multiply of the mantissa with itself, truncating normalisation.
module square_iter #(
  parameter int ITER_MAX = 11
) (
  input  logic clk,
  input  logic rst,
  square_iter_if.slave bus
);

  localparam int MW = 11;
  localparam int PW = 2 * MW;
  localparam int CW = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state_q;
  logic [MW-1:0]     mcand_q;
  logic [MW-1:0]     mplier_q;
  logic [PW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic signed [6:0] exp_q;

  logic              busy_q;
  logic              itv_q;
  logic              res_q;
  logic              sign_q;
  logic signed [6:0] expo_q;
  logic [MW-1:0]     mant_q;
  logic              nan_q;
  logic              pinf_q;
  logic              ninf_q;

  logic [PW-1:0]     addend_d;
  logic [PW-1:0]     prod_d;
  logic              hi_d;
  logic [MW-1:0]     mant_d;
  logic signed [7:0] e_d;
  logic              last_d;
  logic              nan_in_d;
  logic              inf_in_d;
  logic              zero_in_d;

  // Next partial product and the normalised view of it.
  always_comb begin
    addend_d = '0;
    if (mplier_q[0])
      addend_d = {{MW{1'b0}}, mcand_q} << cnt_q;
    prod_d = acc_q + addend_d;
    hi_d   = prod_d[PW-1];
    mant_d = hi_d ? prod_d[PW-1:MW]
                  : prod_d[PW-2:MW-1];
    // {exp, hi} is 2*exp + hi in 8-bit signed.
    e_d    = signed'({exp_q, hi_d});
    last_d = (cnt_q == CW'(ITER_MAX - 1));
  end

  // Operand classification, highest priority first.
  always_comb begin
    nan_in_d  = bus.is_nan_in |
                (!bus.is_num &&
                 !bus.is_pinf_in &&
                 !bus.is_ninf_in);
    inf_in_d  = bus.is_pinf_in | bus.is_ninf_in;
    zero_in_d = (bus.exp_in == -7'sd15);
  end

  // Control FSM, multiplier datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      busy_q   <= 1'b0;
      itv_q    <= 1'b0;
      res_q    <= 1'b0;
      sign_q   <= 1'b0;
      expo_q   <= '0;
      mant_q   <= '0;
      nan_q    <= 1'b0;
      pinf_q   <= 1'b0;
      ninf_q   <= 1'b0;
    end else begin
      res_q <= 1'b0;
      itv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.n_valid) begin
            if (nan_in_d) begin
              res_q  <= 1'b1;
              itv_q  <= 1'b1;
              sign_q <= 1'b1;
              expo_q <= 7'sd16;
              mant_q <= 11'b100_0000_0000;
              nan_q  <= 1'b1;
              pinf_q <= 1'b0;
              ninf_q <= 1'b0;
            end else if (inf_in_d) begin
              res_q  <= 1'b1;
              itv_q  <= 1'b1;
              sign_q <= 1'b0;
              expo_q <= 7'sd16;
              mant_q <= '0;
              nan_q  <= 1'b0;
              pinf_q <= 1'b1;
              ninf_q <= 1'b0;
            end else if (zero_in_d) begin
              res_q  <= 1'b1;
              itv_q  <= 1'b1;
              sign_q <= 1'b0;
              expo_q <= -7'sd15;
              mant_q <= '0;
              nan_q  <= 1'b0;
              pinf_q <= 1'b0;
              ninf_q <= 1'b0;
            end else begin
              mcand_q  <= bus.mant_in;
              mplier_q <= bus.mant_in;
              exp_q    <= bus.exp_in;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              itv_q    <= 1'b1;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          itv_q    <= 1'b1;
          acc_q    <= prod_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            res_q   <= 1'b1;
            sign_q  <= 1'b0;
            nan_q   <= 1'b0;
            ninf_q  <= 1'b0;
            if (e_d > 8'sd15) begin
              expo_q <= 7'sd16;
              mant_q <= '0;
              pinf_q <= 1'b1;
            end else if (e_d < -8'sd14) begin
              expo_q <= -7'sd15;
              mant_q <= '0;
              pinf_q <= 1'b0;
            end else begin
              expo_q <= e_d[6:0];
              mant_q <= mant_d;
              pinf_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.it_valid    = itv_q;
  assign bus.result      = res_q;
  assign bus.sign_out    = sign_q;
  assign bus.exp_out     = expo_q;
  assign bus.mant_out    = mant_q;
  assign bus.is_nan_out  = nan_q;
  assign bus.is_pinf_out = pinf_q;
  assign bus.is_ninf_out = ninf_q;

endmodule

// File: tb/tb_square_iter.sv
// Directed bench for square_iter: normal squares, range edges,
// specials, ignored mid-run strobe, mid-run reset, throughput.
module tb_square_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  square_iter_if bus ();

  square_iter #(.ITER_MAX(11)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] pk(
    input logic s, input logic signed [6:0] e,
    input logic [10:0] m, input logic n,
    input logic p, input logic ni);
    return {s, e, m, n, p, ni};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.sign_out, bus.exp_out, bus.mant_out,
            bus.is_nan_out, bus.is_pinf_out,
            bus.is_ninf_out};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] x);
    n_chk++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, o, x);
    end
  endtask

  task automatic drive(input logic s,
                       input logic [10:0] m,
                       input logic signed [6:0] e,
                       input logic n, input logic p,
                       input logic ni, input logic num);
    bus.sign_in    = s;
    bus.mant_in    = m;
    bus.exp_in     = e;
    bus.is_nan_in  = n;
    bus.is_pinf_in = p;
    bus.is_ninf_in = ni;
    bus.is_num     = num;
  endtask

  // Counts cycles after the accept edge until result is seen.
  task automatic wait_res(input int inject,
                          output int cyc,
                          output logic b1,
                          output logic v1);
    cyc = 1;
    b1  = bus.busy;
    v1  = bus.it_valid;
    while (!bus.result && cyc < 40) begin
      if (cyc == inject) begin
        bus.n_valid = 1'b1;
        bus.mant_in = 11'h7FF;
        bus.exp_in  = 7'sd2;
      end else begin
        bus.n_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.n_valid = 1'b0;
  endtask

  // Apply one operand at the current negedge and check the result.
  task automatic op(input string tag,
                    input logic s,
                    input logic [10:0] m,
                    input logic signed [6:0] e,
                    input logic n, input logic p,
                    input logic ni, input logic num,
                    input logic [21:0] xres,
                    input int xlat,
                    input int inject);
    int   cyc;
    logic b1;
    logic v1;
    drive(s, m, e, n, p, ni, num);
    bus.n_valid = 1'b1;
    @(negedge clk);
    bus.n_valid = 1'b0;
    wait_res(inject, cyc, b1, v1);
    chk({tag, "_lat"}, cyc, xlat);
    chk({tag, "_busy"}, b1, (xlat > 1));
    chk({tag, "_itv"}, v1, 1);
    chk({tag, "_out"}, obs(), xres);
    @(negedge clk);
    chk({tag, "_pulse"},
        {bus.result, bus.it_valid, bus.busy}, 0);
  endtask

  initial begin
    int c1;
    int c2;
    bus.n_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_out", obs(), 0);
    chk("reset_ctl",
        {bus.result, bus.it_valid, bus.busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    op("one", 0, 11'h400, 0, 0, 0, 0, 1,
       pk(0, 0, 11'h400, 0, 0, 0), 12, 0);
    op("three", 0, 11'h600, 1, 0, 0, 0, 1,
       pk(0, 3, 11'h480, 0, 0, 0), 12, 0);
    op("neg3", 1, 11'h600, 1, 0, 0, 0, 1,
       pk(0, 3, 11'h480, 0, 0, 0), 12, 0);
    op("ones", 0, 11'h7FF, 0, 0, 0, 0, 1,
       pk(0, 1, 11'h7FE, 0, 0, 0), 12, 0);
    op("e14", 0, 11'h400, 7, 0, 0, 0, 1,
       pk(0, 14, 11'h400, 0, 0, 0), 12, 0);
    op("e15", 0, 11'h600, 7, 0, 0, 0, 1,
       pk(0, 15, 11'h480, 0, 0, 0), 12, 0);
    op("ovf", 0, 11'h400, 8, 0, 0, 0, 1,
       pk(0, 16, 11'h000, 0, 1, 0), 12, 0);
    op("em14", 0, 11'h400, -7, 0, 0, 0, 1,
       pk(0, -14, 11'h400, 0, 0, 0), 12, 0);
    op("uflow", 0, 11'h400, -8, 0, 0, 0, 1,
       pk(0, -15, 11'h000, 0, 0, 0), 12, 0);

    op("nan", 0, 11'h123, 3, 1, 0, 0, 0,
       pk(1, 16, 11'h400, 1, 0, 0), 1, 0);
    op("ninf", 1, 11'h000, 16, 0, 0, 1, 0,
       pk(0, 16, 11'h000, 0, 1, 0), 1, 0);
    op("zero", 1, 11'h555, -15, 0, 0, 0, 1,
       pk(0, -15, 11'h000, 0, 0, 0), 1, 0);
    op("nonum", 0, 11'h400, 0, 0, 0, 0, 0,
       pk(1, 16, 11'h400, 1, 0, 0), 1, 0);

    op("ignore", 0, 11'h600, 1, 0, 0, 0, 1,
       pk(0, 3, 11'h480, 0, 0, 0), 12, 5);

    drive(0, 11'h7FF, 0, 0, 0, 0, 1);
    bus.n_valid = 1'b1;
    @(negedge clk);
    bus.n_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out", obs(), 0);
    chk("rst_ctl",
        {bus.result, bus.it_valid, bus.busy}, 0);
    rst = 1'b0;
    op("after", 0, 11'h600, 1, 0, 0, 0, 1,
       pk(0, 3, 11'h480, 0, 0, 0), 12, 0);

    c1 = 0;
    c2 = 0;
    drive(0, 11'h400, 0, 0, 0, 0, 1);
    bus.n_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.result) begin
        if (c1 == 0) c1 = i;
        else if (c2 == 0) c2 = i;
      end
      if (c2 != 0) break;
    end
    bus.n_valid = 1'b0;
    chk("tput_first", c1, 12);
    chk("tput_second", c2, 24);
    chk("tput_out", obs(), pk(0, 0, 11'h400, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("tput_idle", {bus.busy, bus.result}, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
